ctrl_fsm_hs: RTL

Parametrised multicycle control unit for the 32-bit accumulator-less RISC datapath. It decodes the 6-bit opcode/funct ISA. It replaces the enter-strobe I/O and fixed-latency memory with valid/ready handshakes, tracks return-stack occupancy with overflow/underflow faults, traps illegal opcodes, and supports resume from halt. It sits between the instruction register and the datapath muxes/write-enables, alongside the ALU control decoder.

---
 rtl/ctrl_fsm_hs.sv | 333 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_fsm_hs.sv
// Multicycle control FSM for the 32-bit RISC datapath, with handshaked memory/I-O and return-stack fault tracking.
// Latency: state, sp_count and fault_code are registered; all other outputs decode combinationally from state and inputs.
// Backpressure: MEM_RD/MEM_WR wait on mem_ready, IN_WAIT on in_valid, OUT_WAIT on out_ready; HALT waits on resume.
module ctrl_fsm_hs #(
  parameter int OPW          = 6,
  parameter int ILLEGAL_BASE = 24,
  parameter int DEPTH        = 8,
  parameter int SPW          = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] i_opcode,
  input  logic           i_zero,
  input  logic           i_mem_ready,
  input  logic           i_in_valid,
  input  logic           i_out_ready,
  input  logic           i_resume,
  output logic [4:0]     o_state,
  output logic           o_pc_we,
  output logic           o_ir_we,
  output logic           o_reg_we,
  output logic           o_mem_we,
  output logic           o_mem_req,
  output logic           o_in_ready,
  output logic           o_out_valid,
  output logic           o_push,
  output logic           o_pop,
  output logic [1:0]     o_alu_op,
  output logic [1:0]     o_sel_pc,
  output logic [1:0]     o_sel_alu_b,
  output logic           o_sel_mem,
  output logic           o_sel_reg1,
  output logic           o_sel_reg2,
  output logic           o_sel_alu_a,
  output logic           o_sel_in,
  output logic [SPW-1:0] o_sp_count,
  output logic           o_halted,
  output logic           o_fault,
  output logic [1:0]     o_fault_code
);

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_ADDR     = 5'd2,
    S_MEM_RD   = 5'd3,
    S_WB_MEM   = 5'd4,
    S_MEM_WR   = 5'd5,
    S_EXEC_R   = 5'd6,
    S_EXEC_I   = 5'd7,
    S_WB_ALU   = 5'd8,
    S_BR_CALC  = 5'd9,
    S_BR_DONE  = 5'd10,
    S_JUMP     = 5'd11,
    S_RET      = 5'd12,
    S_IN_WAIT  = 5'd13,
    S_OUT_WAIT = 5'd14,
    S_HALT     = 5'd15,
    S_FAULT    = 5'd16
  } state_t;

  // Opcode map of the ISA.
  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_I_LO = OPW'(1);
  localparam logic [OPW-1:0] OP_I_HI = OPW'(9);
  localparam logic [OPW-1:0] OP_B_LO = OPW'(10);
  localparam logic [OPW-1:0] OP_B_HI = OPW'(13);
  localparam logic [OPW-1:0] OP_STI  = OPW'(14);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(15);
  localparam logic [OPW-1:0] OP_STR  = OPW'(16);
  localparam logic [OPW-1:0] OP_LDR  = OPW'(17);
  localparam logic [OPW-1:0] OP_IN   = OPW'(19);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(20);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(21);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(22);
  localparam logic [OPW-1:0] OP_JST  = OPW'(23);
  localparam logic [OPW-1:0] OP_ILL  = OPW'(ILLEGAL_BASE);

  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_ILL   = 2'b01;
  localparam logic [1:0] FC_OVER  = 2'b10;
  localparam logic [1:0] FC_UNDER = 2'b11;

  state_t         r_state;
  state_t         w_next;
  logic [SPW-1:0] r_sp_count;
  logic [1:0]     r_fault_code;
  logic [1:0]     w_fault_code;

  logic w_illegal;
  logic w_is_r;
  logic w_is_i;
  logic w_is_br;
  logic w_is_mem;
  logic w_is_load;
  logic w_is_imm_mem;
  logic w_sp_empty;
  logic w_sp_full;

  // Opcode classes; the IR is stable for the whole instruction, so these hold across its states.
  assign w_illegal    = (i_opcode >= OP_ILL);
  assign w_is_r       = (i_opcode == OP_R);
  assign w_is_i       = (i_opcode >= OP_I_LO) && (i_opcode <= OP_I_HI);
  assign w_is_br      = (i_opcode >= OP_B_LO) && (i_opcode <= OP_B_HI);
  assign w_is_mem     = (i_opcode >= OP_STI) && (i_opcode <= OP_LDR);
  assign w_is_load    = (i_opcode == OP_LDI) || (i_opcode == OP_LDR);
  assign w_is_imm_mem = (i_opcode == OP_STI) || (i_opcode == OP_LDI);
  assign w_sp_empty   = (r_sp_count == '0);
  assign w_sp_full    = (r_sp_count == SP_FULL);

  assign o_state      = r_state;
  assign o_sp_count   = r_sp_count;
  assign o_fault_code = r_fault_code;

  // State, stack occupancy and fault code; the code latches only on the transition into FAULT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_sp_count   <= '0;
      r_fault_code <= FC_NONE;
    end else begin
      r_state <= w_next;
      if (o_push) begin
        r_sp_count <= r_sp_count + SPW'(1);
      end else if (o_pop) begin
        r_sp_count <= r_sp_count - SPW'(1);
      end
      if ((w_next == S_FAULT) && (r_state != S_FAULT)) begin
        r_fault_code <= w_fault_code;
      end
    end
  end

  // Next-state and per-state control decode; every output defaults to 0.
  always_comb begin
    w_next        = r_state;
    w_fault_code  = FC_NONE;
    o_pc_we       = 1'b0;
    o_ir_we       = 1'b0;
    o_reg_we      = 1'b0;
    o_mem_we      = 1'b0;
    o_mem_req     = 1'b0;
    o_in_ready    = 1'b0;
    o_out_valid   = 1'b0;
    o_push        = 1'b0;
    o_pop         = 1'b0;
    o_alu_op      = 2'b00;
    o_sel_pc      = 2'b00;
    o_sel_alu_b   = 2'b00;
    o_sel_mem     = 1'b0;
    o_sel_reg1    = 1'b0;
    o_sel_reg2    = 1'b0;
    o_sel_alu_a   = 1'b0;
    o_sel_in      = 1'b0;
    o_halted      = 1'b0;
    o_fault       = 1'b0;

    case (r_state)
      S_FETCH: begin
        o_ir_we     = 1'b1;
        o_alu_op    = 2'b01;
        o_sel_alu_b = 2'b01;
        w_next      = S_DECODE;
      end

      S_DECODE: begin
        o_pc_we = 1'b1;
        if (w_illegal) begin
          o_pc_we      = 1'b0;
          w_fault_code = FC_ILL;
          w_next       = S_FAULT;
        end else if (w_is_r) begin
          w_next = S_EXEC_R;
        end else if (w_is_i) begin
          w_next = S_EXEC_I;
        end else if (w_is_mem) begin
          w_next = S_ADDR;
        end else if (w_is_br) begin
          w_next = S_BR_CALC;
        end else if ((i_opcode == OP_JMP) || (i_opcode == OP_JAL)) begin
          w_next = S_JUMP;
        end else if (i_opcode == OP_JST) begin
          // Return with nothing on the stack aborts before touching the PC.
          if (w_sp_empty) begin
            o_pc_we      = 1'b0;
            w_fault_code = FC_UNDER;
            w_next       = S_FAULT;
          end else begin
            w_next = S_RET;
          end
        end else if (i_opcode == OP_IN) begin
          w_next = S_IN_WAIT;
        end else if (i_opcode == OP_OUT) begin
          w_next = S_OUT_WAIT;
        end else begin
          w_next = S_HALT;
        end
      end

      S_ADDR: begin
        o_sel_mem   = 1'b1;
        o_sel_alu_a = 1'b1;
        o_sel_alu_b = 2'b11;
        o_alu_op    = w_is_imm_mem ? 2'b11 : 2'b01;
        w_next      = w_is_load ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        o_mem_req  = 1'b1;
        o_sel_mem  = 1'b1;
        o_sel_reg2 = 1'b1;
        if (i_mem_ready) begin
          w_next = S_WB_MEM;
        end
      end

      S_WB_MEM: begin
        o_reg_we   = 1'b1;
        o_sel_mem  = 1'b1;
        o_sel_reg2 = 1'b1;
        w_next     = S_FETCH;
      end

      S_MEM_WR: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_sel_mem   = 1'b1;
        o_sel_alu_a = 1'b1;
        if (i_mem_ready) begin
          w_next = S_FETCH;
        end
      end

      S_EXEC_R: begin
        o_sel_reg1  = 1'b1;
        o_sel_alu_a = 1'b1;
        w_next      = S_WB_ALU;
      end

      S_EXEC_I: begin
        o_sel_alu_a = 1'b1;
        o_sel_alu_b = 2'b11;
        w_next      = S_WB_ALU;
      end

      S_WB_ALU: begin
        o_reg_we    = 1'b1;
        o_sel_alu_a = 1'b1;
        if (w_is_r) begin
          o_sel_reg1  = 1'b1;
          o_sel_alu_b = 2'b00;
        end else begin
          o_sel_alu_b = 2'b11;
        end
        w_next = S_FETCH;
      end

      S_BR_CALC: begin
        o_sel_pc    = 2'b01;
        o_sel_alu_a = 1'b1;
        w_next      = S_BR_DONE;
      end

      S_BR_DONE: begin
        o_sel_pc = 2'b10;
        o_alu_op = 2'b11;
        o_pc_we  = i_zero;
        w_next   = S_FETCH;
      end

      S_JUMP: begin
        o_alu_op    = 2'b11;
        o_sel_alu_a = 1'b1;
        o_sel_alu_b = 2'b11;
        if ((i_opcode == OP_JAL) && w_sp_full) begin
          w_fault_code = FC_OVER;
          w_next       = S_FAULT;
        end else begin
          o_pc_we = 1'b1;
          o_push  = (i_opcode == OP_JAL);
          w_next  = S_FETCH;
        end
      end

      S_RET: begin
        o_sel_pc = 2'b11;
        // Guard kept so the counter can never wrap even if entered with an empty stack.
        if (w_sp_empty) begin
          w_fault_code = FC_UNDER;
          w_next       = S_FAULT;
        end else begin
          o_pc_we = 1'b1;
          o_pop   = 1'b1;
          w_next  = S_FETCH;
        end
      end

      S_IN_WAIT: begin
        o_in_ready = 1'b1;
        o_sel_in   = 1'b1;
        o_reg_we   = i_in_valid;
        if (i_in_valid) begin
          w_next = S_FETCH;
        end
      end

      S_OUT_WAIT: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_next = S_FETCH;
        end
      end

      S_HALT: begin
        o_halted = 1'b1;
        if (i_resume) begin
          w_next = S_FETCH;
        end
      end

      S_FAULT: begin
        o_fault = 1'b1;
      end

      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

endmodule
